// File: rtl/bf16_add_arbiter_pkg.sv
// Shared types for the bf16 adder arbiter.
// Holds the bf16 word type, quiet-NaN constant and FSM state enum.
package bf16_pkg;

  typedef logic [15:0] bf16_t;

  localparam bf16_t BF16_QNAN = 16'h7FC0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } arb_state_t;

endpackage

// File: rtl/bf16_add_arbiter_if.sv
// Requester, response and adder-side signals of the bf16 arbiter.
// master = the arbiter itself, slave = clients plus the adder.
interface bf16_add_arbiter_if
  import bf16_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*16-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  bf16_t                 rsp_sum;
  logic                  rsp_error;

  logic                  add_start;
  bf16_t                 add_a;
  bf16_t                 add_b;
  logic                  add_done;
  bf16_t                 add_sum;

  logic                  busy;

  modport master (
    input  req_valid, req_a, req_b,
    input  rsp_ready, add_done, add_sum,
    output req_ready, rsp_valid, rsp_id,
    output rsp_sum, rsp_error,
    output add_start, add_a, add_b, busy
  );

  modport slave (
    output req_valid, req_a, req_b,
    output rsp_ready, add_done, add_sum,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_sum, rsp_error,
    input  add_start, add_a, add_b, busy
  );

endinterface

// File: rtl/bf16_add_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or
// above ptr, searching upward with wrap.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            grant_any,
  output logic [ID_W-1:0] grant_idx
);

  always_comb begin
    int j;
    grant_any = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!grant_any && req[j]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/bf16_add_arbiter.sv
// Round-robin sharing of one bf16 adder among NUM_REQ clients.
// Optional watchdog: define BF16_ARB_TIMEOUT_EN.
module bf16_add_arbiter
  import bf16_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input logic               clock,
  input logic               nreset,
  bf16_add_arbiter_if.master io
);

  if (NUM_REQ < 2 || NUM_REQ > 16 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("bf16_add_arbiter: bad parameters");
  end

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  bf16_t           a_q, a_d;
  bf16_t           b_q, b_d;
  bf16_t           sum_q, sum_d;
  logic [NUM_REQ-1:0] req_ready;
  logic            grant_any;
  logic [ID_W-1:0] grant_idx;
  logic            in_op;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req       (io.req_valid),
    .ptr       (rr_ptr_q),
    .grant_any (grant_any),
    .grant_idx (grant_idx)
  );

`ifdef BF16_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q, err_d;
  logic             timeout;

  assign timeout =
    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // cleared in ISSUE so the first WAIT cycle sees zero
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign io.rsp_error = err_q;
`else
  assign io.rsp_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    req_ready = '0;
`ifdef BF16_ARB_TIMEOUT_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready[grant_idx] = 1'b1;
          id_d  = grant_idx;
          a_d   = io.req_a[16*int'(grant_idx) +: 16];
          b_d   = io.req_b[16*int'(grant_idx) +: 16];
          rr_ptr_d =
            (grant_idx == ID_W'(NUM_REQ - 1)) ?
            '0 : grant_idx + ID_W'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done beats a same-cycle watchdog expiry
        if (io.add_done) begin
          sum_d   = io.add_sum;
          state_d = ST_RESPOND;
`ifdef BF16_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (timeout) begin
          sum_d   = BF16_QNAN;
          err_d   = 1'b1;
          state_d = ST_RESPOND;
`endif
        end
      end
      ST_RESPOND: begin
        if (io.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_op = (state_q == ST_ISSUE) ||
                 (state_q == ST_WAIT);

  assign io.req_ready = req_ready;
  assign io.add_start = (state_q == ST_ISSUE);
  assign io.add_a     = in_op ? a_q : '0;
  assign io.add_b     = in_op ? b_q : '0;
  assign io.rsp_valid = (state_q == ST_RESPOND);
  assign io.rsp_id    = id_q;
  assign io.rsp_sum   = sum_q;
  assign io.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bf16_add_arbiter.sv
// Self-checking bench for bf16_add_arbiter with a model adder
// of programmable latency and a response scoreboard.
module tb_bf16_add_arbiter;
  import bf16_pkg::*;

  localparam int NUM = 4;
  localparam int TO  = 8;

  typedef struct {
    int    id;
    bf16_t a;
    bf16_t b;
    int    lat;
    bf16_t sum;
    bit    err;
  } vec_t;

  typedef struct {
    int    id;
    bf16_t sum;
    bit    err;
  } exp_t;

  logic clock;
  logic nreset;

  bf16_add_arbiter_if #(.NUM_REQ(NUM)) io ();

  bf16_add_arbiter #(
    .NUM_REQ        (NUM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock  (clock),
    .nreset (nreset),
    .io     (io.master)
  );

  int   tests = 0;
  int   fails = 0;
  int   lat   = 1;
  bit   hang  = 0;
  bit   stray = 0;
  int   exp_ptr = 0;
  exp_t sbq[$];
  vec_t vt[7];
  bf16_t fa[NUM];
  bf16_t fb[NUM];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  function automatic bf16_t ref_add(bf16_t a, bf16_t b);
    case ({a, b})
      32'h3F80_4000: return 16'h4040;
      32'h7F80_FF80: return 16'h7FC0;
      32'h0000_8000: return 16'h0000;
      32'h0001_0001: return 16'h0002;
      32'h4000_4000: return 16'h4080;
      32'h7FC1_3F80: return 16'h7FC1;
      32'h3F80_3F80: return 16'h4000;
      default:       return a ^ b;
    endcase
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic sb_push(input int id,
                         input bf16_t s,
                         input bit e);
    exp_t x;
    x.id  = id;
    x.sum = s;
    x.err = e;
    sbq.push_back(x);
  endtask

  task automatic rst_chk(input string nm);
    check({nm, "_ctl"},
          {io.req_ready, io.rsp_valid, io.rsp_id,
           io.rsp_error, io.add_start, io.busy}, 0);
    check({nm, "_sum"}, io.rsp_sum, 0);
    check({nm, "_ops"}, {io.add_a, io.add_b}, 0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (io.busy && n < 80) begin
      step();
      n++;
    end
    check("idle_timeout", n < 80, 1);
  endtask

  // model adder: done L cycles after the start cycle
  initial begin
    bf16_t la, lb;
    int    pend;
    pend = 0;
    la = '0;
    lb = '0;
    io.add_done = 1'b0;
    io.add_sum  = '0;
    forever begin
      @(negedge clock);
      if (io.add_start) begin
        la   = io.add_a;
        lb   = io.add_b;
        pend = lat;
      end
      @(posedge clock);
      #1;
      io.add_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !hang) begin
          io.add_done = 1'b1;
          io.add_sum  = ref_add(la, lb);
        end
      end
      if (stray) begin
        io.add_done = 1'b1;
        io.add_sum  = 16'hBEEF;
        stray = 1'b0;
      end
    end
  end

  // scoreboard: compare every response handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (nreset && io.rsp_valid && io.rsp_ready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra: id %0d sum %0h",
                   io.rsp_id, io.rsp_sum);
        end else begin
          e = sbq.pop_front();
          check("rsp_id", io.rsp_id, e.id);
          check("rsp_sum", io.rsp_sum, e.sum);
          check("rsp_err", io.rsp_error, e.err);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int t_st, t_rsp;
    t_st  = -1;
    t_rsp = -1;
    lat = v.lat;
    io.req_a[16*v.id +: 16] = v.a;
    io.req_b[16*v.id +: 16] = v.b;
    io.req_valid = NUM'(1) << v.id;
    sb_push(v.id, v.sum, v.err);
    @(negedge clock);
    check("grant", io.req_ready, NUM'(1) << v.id);
    step();
    io.req_valid = '0;
    exp_ptr = (v.id + 1) % NUM;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (io.add_start && t_st < 0) t_st = c;
      if (io.add_start ||
          (io.busy && !io.rsp_valid)) begin
        check("add_a", io.add_a, v.a);
        check("add_b", io.add_b, v.b);
      end
      if (io.rsp_valid) t_rsp = c;
      step();
      if (t_rsp >= 0) break;
    end
    check("start_cyc", t_st, 1);
    check("rsp_cyc", t_rsp, 2 + v.lat);
  endtask

  initial begin
    int grants, last, bad;

    vt[0] = '{2, 16'h3F80, 16'h4000, 5, 16'h4040, 0};
    vt[1] = '{0, 16'h7F80, 16'hFF80, 3, 16'h7FC0, 0};
    vt[2] = '{3, 16'h0000, 16'h8000, 1, 16'h0000, 0};
    vt[3] = '{1, 16'h0001, 16'h0001, 2, 16'h0002, 0};
    vt[4] = '{2, 16'h4000, 16'h4000, 8, 16'h4080, 0};
    vt[5] = '{3, 16'h7FC1, 16'h3F80, 4, 16'h7FC1, 0};
    vt[6] = '{1, 16'h3F80, 16'h3F80, 6, 16'h4000, 0};
    for (int i = 0; i < NUM; i++) begin
      fa[i] = 16'h3F00 + 16'(i * 16'h11);
      fb[i] = 16'h4100 + 16'(i * 16'h23);
    end

    nreset       = 1'b0;
    io.req_valid = '0;
    io.req_a     = '0;
    io.req_b     = '0;
    io.rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_chk("reset");
    step();
    nreset = 1'b1;
    step();

    foreach (vt[i]) run_vec(vt[i]);

    // fairness with all requesters valid
    lat = 2;
    for (int i = 0; i < NUM; i++) begin
      io.req_a[16*i +: 16] = fa[i];
      io.req_b[16*i +: 16] = fb[i];
    end
    io.req_valid = '1;
    grants = 0;
    last   = -1;
    for (int c = 0; c < 200 && grants < 8; c++) begin
      @(negedge clock);
      if (io.req_ready != 0) begin
        check("fair_grant", io.req_ready,
              NUM'(1) << exp_ptr);
        if (last >= 0)
          check("fair_period", c - last, lat + 3);
        last = c;
        sb_push(exp_ptr,
                ref_add(fa[exp_ptr], fb[exp_ptr]), 0);
        exp_ptr = (exp_ptr + 1) % NUM;
        grants++;
      end
      step();
    end
    check("fair_count", grants, 8);
    io.req_valid = '0;
    wait_idle();

    // backpressure on the response side
    io.rsp_ready = 1'b0;
    lat = 3;
    io.req_a[16 +: 16] = 16'h3F80;
    io.req_b[16 +: 16] = 16'h3F80;
    io.req_valid = 4'b0010;
    sb_push(1, 16'h4000, 0);
    @(negedge clock);
    check("bp_grant", io.req_ready, 4'b0010);
    step();
    io.req_a[15:0] = 16'h4000;
    io.req_b[15:0] = 16'h4000;
    io.req_valid = 4'b0001;
    sb_push(0, 16'h4080, 0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (io.rsp_valid) break;
      step();
    end
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clock);
      check("bp_valid", io.rsp_valid, 1);
      check("bp_id", io.rsp_id, 1);
      check("bp_sum", io.rsp_sum, 16'h4000);
      check("bp_noready", io.req_ready, 0);
      step();
    end
    io.rsp_ready = 1'b1;
    @(negedge clock);
    check("bp_hs_valid", io.rsp_valid, 1);
    check("bp_hs_nogrant", io.req_ready, 0);
    step();
    @(negedge clock);
    check("bp_next_grant", io.req_ready, 4'b0001);
    exp_ptr = 1;
    step();
    io.req_valid = '0;
    wait_idle();

    // reset while waiting on the adder
    lat = 6;
    io.req_a[32 +: 16] = 16'h3F80;
    io.req_b[32 +: 16] = 16'h4000;
    io.req_valid = 4'b0100;
    @(negedge clock);
    check("rw_grant", io.req_ready, 4'b0100);
    step();
    io.req_valid = '0;
    step();
    step();
    nreset = 1'b0;
    @(negedge clock);
    rst_chk("rw_reset");
    step();
    nreset = 1'b1;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (io.rsp_valid || io.busy) bad++;
      step();
    end
    check("rw_quiet", bad, 0);
    for (int i = 0; i < NUM; i++) begin
      io.req_a[16*i +: 16] = fa[i];
      io.req_b[16*i +: 16] = fb[i];
    end
    io.req_valid = '1;
    @(negedge clock);
    check("rw_ptr0", io.req_ready, 4'b0001);
    sb_push(0, ref_add(fa[0], fb[0]), 0);
    step();
    io.req_valid = '0;
    wait_idle();

`ifdef BF16_ARB_TIMEOUT_EN
    hang = 1'b1;
    run_vec('{1, 16'h3F80, 16'h4000, TO,
              BF16_QNAN, 1});
    hang = 1'b0;
`endif

    // a done pulse with nothing in flight is ignored
    stray = 1'b1;
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      if (io.rsp_valid || io.busy) bad++;
      step();
    end
    check("stray_done", bad, 0);

    check("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/bf16_add_arbiter.md
# bf16_add_arbiter

Shares one bfloat16 adder among NUM_REQ independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants requesters round-robin, drives the adder with a start pulse, waits for its done pulse, and returns the sum tagged with the requester index. It sits between the compute clients and the single adder instance, so the adder is never driven by more than one source.

## Interface
- NUM_REQ, default 4: number of requesters; legal range 2..16.
- TIMEOUT_CYCLES, default 64: watchdog limit in cycles; used only when the watchdog is compiled in.
- ID_W, default $clog2(NUM_REQ): derived width of the requester index; not overridden.
- clock  input  1  rising-edge clock.
- nreset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_a  input  NUM_REQ*16  packed operand A; requester i uses bits [16i+15:16i].
- req_b  input  NUM_REQ*16  packed operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot accept pulse.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  result consumer ready.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_sum  output  16  bfloat16 sum.
- rsp_error  output  1  result produced by a watchdog timeout.
- add_start  output  1  one-cycle start pulse to the adder.
- add_a, add_b  output  16 each  adder operands.
- add_done  input  1  adder completion pulse.
- add_sum  input  16  adder result; valid while add_done is high.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any req_valid is high, grant the first valid requester at or after rr_ptr, searching upward with wrap.
  - Assert req_ready[g] for this one cycle only, latch req_a/req_b of g and g itself, then go to ISSUE.
  - Update rr_ptr to (g+1) mod NUM_REQ; at g=NUM_REQ-1 it wraps to 0.
- ISSUE: add_start=1 for exactly one cycle, then go to WAIT.
- add_a/add_b are driven from the latched operands from ISSUE until the exit from WAIT, and must stay stable throughout.
- WAIT: when add_done=1, capture add_sum into rsp_sum, set rsp_error=0, go to RESPOND.
- RESPOND:
  - rsp_valid=1, with rsp_id and rsp_sum held stable.
  - When rsp_valid & rsp_ready, go to IDLE.
  - The next grant can occur in the cycle after that handshake, not the same cycle.
- add_done arriving in IDLE, ISSUE or RESPOND is ignored.
- The adder must not raise done in the same cycle as start.
- Only one operation is in flight at a time; no new request is accepted before the response handshake.
- A requester that drops req_valid before its grant simply loses its turn; no state is kept for it.
- The block does no arithmetic. Operands pass through unmodified, including zero, subnormal, Inf and NaN encodings.

## Timing
- Reset values: state=IDLE, rr_ptr=0, and every output 0 (req_ready, rsp_valid, rsp_id, rsp_sum, rsp_error, add_start, add_a, add_b, busy).
- nreset asserted mid-operation aborts the transaction with no response. A later add_done from the old operation lands in IDLE and is ignored.
- With adder latency L, measured from add_start to add_done:
  - grant at cycle 0;
  - add_start at cycle 1;
  - add_done at cycle 1+L;
  - rsp_valid from cycle 2+L.
- Minimum request-to-request period is L+3 cycles when rsp_ready is held high.
- If all requesters hold req_valid high continuously, grant order is rr_ptr, rr_ptr+1, … with wrap, so every requester is served within NUM_REQ grants.

## Configuration
- BF16_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without add_done, go to RESPOND with rsp_sum=16'h7FC0 (quiet NaN) and rsp_error=1.
  - If add_done arrives in the same cycle the counter reaches its limit, add_done wins: rsp_sum=add_sum and rsp_error=0.
- BF16_ARB_TIMEOUT_EN undefined: WAIT lasts until add_done, no counter logic exists, and rsp_error is constant 0.

## Structure
- Package bf16_pkg holds:
  - typedef bf16_t as a 16-bit logic vector;
  - constant BF16_QNAN=16'h7FC0;
  - the arbiter state enum type.
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], ptr[ID_W];
  - outputs: grant_any, grant_idx;
  - purely combinational round-robin pick.
  - rr_ptr, the FSM and the datapath latches stay in bf16_add_arbiter.

## Test plan
- Single request: requester 2 sends a=16'h3F80 (1.0), b=16'h4000 (2.0); model adder with L=5 → req_ready[2] pulses at cycle 0, add_start at cycle 1, rsp_valid at cycle 7 with rsp_id=2 and rsp_sum=16'h4040 (3.0).
- Fairness: all 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,…, each requester served every 4th grant, no double grant.
- Backpressure: rsp_ready held 0 for 10 cycles after rsp_valid → rsp_valid, rsp_id and rsp_sum stay stable, req_ready stays 0, a single grant follows the handshake.
- Reset in WAIT: assert nreset mid-operation, then the model adder raises add_done → all outputs 0, no rsp_valid, rr_ptr=0.
- Timeout (BF16_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): adder never raises done → rsp_valid with rsp_sum=16'h7FC0 and rsp_error=1 after 8 WAIT cycles; a stray add_done afterwards is ignored.
- Passthrough of special values: a=16'h7F80 (+Inf), b=16'hFF80 (-Inf) → add_a/add_b equal exactly 16'h7F80 and 16'hFF80, and rsp_sum equals the adder's add_sum bit-for-bit.
